// File: rtl/dport_arb2.sv
// ---------------------------------------------------------------------------
// dport_arb2
//
// Two-requester arbiter sharing one dcache_if-style downstream port between
// the CPU load/store port (inport0) and a secondary master such as debug or
// DMA (inport1). Requests are granted round-robin. A grant that is driven but
// not accepted is locked until it is accepted or withdrawn. An in-order
// routing FIFO records the owner of every accepted request, so each
// downstream ack is steered back to the port that issued the request.
//
// Ports
//   clk_i, rst_i             clock, asynchronous active-high reset
//   inportN_*_i              upstream request (addr, wdata, rd, wr strobes,
//                            cacheable, tag, invalidate, flush), N = 0/1
//   inportN_accept_o         request of port N accepted this cycle
//   inportN_ack_o            response belongs to port N
//   inportN_error_o/data_rd_o/resp_tag_o
//                            broadcast response fields (qualified by ack)
//   outport_*_o              muxed downstream request
//   outport_accept_i/ack_i/error_i/data_rd_i/resp_tag_i
//                            downstream handshake and response
//   err_unexpected_o         sticky: ack seen with no outstanding request
// ---------------------------------------------------------------------------
module dport_arb2 #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int OUT_W           = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] inport0_addr_i,
    input  logic [31:0] inport0_data_wr_i,
    input  logic        inport0_rd_i,
    input  logic [3:0]  inport0_wr_i,
    input  logic        inport0_cacheable_i,
    input  logic [10:0] inport0_req_tag_i,
    input  logic        inport0_invalidate_i,
    input  logic        inport0_flush_i,
    output logic        inport0_accept_o,
    output logic        inport0_ack_o,
    output logic        inport0_error_o,
    output logic [31:0] inport0_data_rd_o,
    output logic [10:0] inport0_resp_tag_o,

    input  logic [31:0] inport1_addr_i,
    input  logic [31:0] inport1_data_wr_i,
    input  logic        inport1_rd_i,
    input  logic [3:0]  inport1_wr_i,
    input  logic        inport1_cacheable_i,
    input  logic [10:0] inport1_req_tag_i,
    input  logic        inport1_invalidate_i,
    input  logic        inport1_flush_i,
    output logic        inport1_accept_o,
    output logic        inport1_ack_o,
    output logic        inport1_error_o,
    output logic [31:0] inport1_data_rd_o,
    output logic [10:0] inport1_resp_tag_o,

    output logic [31:0] outport_addr_o,
    output logic [31:0] outport_data_wr_o,
    output logic        outport_rd_o,
    output logic [3:0]  outport_wr_o,
    output logic        outport_cacheable_o,
    output logic [10:0] outport_req_tag_o,
    output logic        outport_invalidate_o,
    output logic        outport_flush_o,
    input  logic        outport_accept_i,
    input  logic        outport_ack_i,
    input  logic        outport_error_i,
    input  logic [31:0] outport_data_rd_i,
    input  logic [10:0] outport_resp_tag_i,

    output logic        err_unexpected_o
);

    localparam logic [OUT_W:0] FULL_CNT = (OUT_W+1)'(MAX_OUTSTANDING);

    // Registered state
    logic             last_q,      last_d;
    logic             lock_q,      lock_d;
    logic             lock_port_q, lock_port_d;
    logic [OUT_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic [OUT_W-1:0] rd_ptr_q,    rd_ptr_d;
    logic [OUT_W:0]   count_q,     count_d;
    logic             err_q,       err_d;
    logic             fifo_q [MAX_OUTSTANDING];

    // Combinational decode
    logic req0, req1;
    logic grant;
    logic req_sel;
    logic full, empty;
    logic out_valid;
    logic fire;
    logic pop;
    logic head;

    assign req0 = inport0_rd_i | (|inport0_wr_i) | inport0_flush_i | inport0_invalidate_i;
    assign req1 = inport1_rd_i | (|inport1_wr_i) | inport1_flush_i | inport1_invalidate_i;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // Round-robin grant; a locked grant overrides arbitration so the
    // downstream request stays stable until accepted or withdrawn.
    // NOTE: every signal assigned in an always_comb gets a default first,
    // so no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        grant = 1'b0;
        if (lock_q)
            grant = lock_port_q;
        else if (req0 && req1)
            grant = ~last_q;
        else if (req1)
            grant = 1'b1;
    end

    assign req_sel   = grant ? req1 : req0;
    assign out_valid = req_sel & ~full;
    assign fire      = out_valid & outport_accept_i;

    // Request mux: attributes follow the grant, strobes are blanked when full
    assign outport_addr_o       = grant ? inport1_addr_i       : inport0_addr_i;
    assign outport_data_wr_o    = grant ? inport1_data_wr_i    : inport0_data_wr_i;
    assign outport_cacheable_o  = grant ? inport1_cacheable_i  : inport0_cacheable_i;
    assign outport_req_tag_o    = grant ? inport1_req_tag_i    : inport0_req_tag_i;
    assign outport_rd_o         = (grant ? inport1_rd_i         : inport0_rd_i) & ~full;
    assign outport_wr_o         = (grant ? inport1_wr_i         : inport0_wr_i) & {4{~full}};
    assign outport_invalidate_o = (grant ? inport1_invalidate_i : inport0_invalidate_i) & ~full;
    assign outport_flush_o      = (grant ? inport1_flush_i      : inport0_flush_i) & ~full;

    assign inport0_accept_o = fire & ~grant;
    assign inport1_accept_o = fire &  grant;

    // Response routing: head of the FIFO names the owner of this ack
    assign head = fifo_q[rd_ptr_q];
    assign pop  = outport_ack_i & ~empty;

    assign inport0_ack_o      = pop & ~head;
    assign inport1_ack_o      = pop &  head;
    assign inport0_error_o    = outport_error_i;
    assign inport1_error_o    = outport_error_i;
    assign inport0_data_rd_o  = outport_data_rd_i;
    assign inport1_data_rd_o  = outport_data_rd_i;
    assign inport0_resp_tag_o = outport_resp_tag_i;
    assign inport1_resp_tag_o = outport_resp_tag_i;

    assign err_unexpected_o = err_q;

    // Next-state logic
    always_comb begin
        last_d      = last_q;
        lock_d      = out_valid & ~outport_accept_i;
        lock_port_d = lock_port_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        err_d       = err_q | (outport_ack_i & empty);

        if (lock_d)
            lock_port_d = grant;

        if (fire) begin
            last_d   = grant;
            wr_ptr_d = wr_ptr_q + OUT_W'(1);
        end

        if (pop)
            rd_ptr_d = rd_ptr_q + OUT_W'(1);

        unique case ({fire, pop})
            2'b10:   count_d = count_q + (OUT_W+1)'(1);
            2'b01:   count_d = count_q - (OUT_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q      <= 1'b1;
            lock_q      <= 1'b0;
            lock_port_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            last_q      <= last_d;
            lock_q      <= lock_d;
            lock_port_q <= lock_port_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_q       <= err_d;
        end
    end

    // NOTE: the routing storage is deliberately not reset; count_q gates
    // every read, so stale entries after reset are never observed.
    always_ff @(posedge clk_i) begin
        if (fire)
            fifo_q[wr_ptr_q] <= grant;
    end

endmodule

// File: tb/tb_dport_arb2.sv
// ---------------------------------------------------------------------------
// tb_dport_arb2
//
// Directed bench for dport_arb2. Inputs change on the falling edge and
// outputs are sampled 1 ns later. Every accepted request pushes its expected
// owner into a scoreboard queue; every downstream ack pops the queue and the
// inport acks are compared against the popped owner.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dport_arb2;

    logic        clk_i;
    logic        rst_i;

    logic [31:0] inport0_addr_i, inport0_data_wr_i;
    logic        inport0_rd_i;
    logic [3:0]  inport0_wr_i;
    logic        inport0_cacheable_i;
    logic [10:0] inport0_req_tag_i;
    logic        inport0_invalidate_i, inport0_flush_i;
    logic        inport0_accept_o, inport0_ack_o, inport0_error_o;
    logic [31:0] inport0_data_rd_o;
    logic [10:0] inport0_resp_tag_o;

    logic [31:0] inport1_addr_i, inport1_data_wr_i;
    logic        inport1_rd_i;
    logic [3:0]  inport1_wr_i;
    logic        inport1_cacheable_i;
    logic [10:0] inport1_req_tag_i;
    logic        inport1_invalidate_i, inport1_flush_i;
    logic        inport1_accept_o, inport1_ack_o, inport1_error_o;
    logic [31:0] inport1_data_rd_o;
    logic [10:0] inport1_resp_tag_o;

    logic [31:0] outport_addr_o, outport_data_wr_o;
    logic        outport_rd_o;
    logic [3:0]  outport_wr_o;
    logic        outport_cacheable_o;
    logic [10:0] outport_req_tag_o;
    logic        outport_invalidate_o, outport_flush_o;
    logic        outport_accept_i, outport_ack_i, outport_error_i;
    logic [31:0] outport_data_rd_i;
    logic [10:0] outport_resp_tag_i;
    logic        err_unexpected_o;

    int total = 0;
    int bad   = 0;
    int sb[$];

    dport_arb2 #(.MAX_OUTSTANDING(4), .OUT_W(2)) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .inport0_addr_i       (inport0_addr_i),
        .inport0_data_wr_i    (inport0_data_wr_i),
        .inport0_rd_i         (inport0_rd_i),
        .inport0_wr_i         (inport0_wr_i),
        .inport0_cacheable_i  (inport0_cacheable_i),
        .inport0_req_tag_i    (inport0_req_tag_i),
        .inport0_invalidate_i (inport0_invalidate_i),
        .inport0_flush_i      (inport0_flush_i),
        .inport0_accept_o     (inport0_accept_o),
        .inport0_ack_o        (inport0_ack_o),
        .inport0_error_o      (inport0_error_o),
        .inport0_data_rd_o    (inport0_data_rd_o),
        .inport0_resp_tag_o   (inport0_resp_tag_o),
        .inport1_addr_i       (inport1_addr_i),
        .inport1_data_wr_i    (inport1_data_wr_i),
        .inport1_rd_i         (inport1_rd_i),
        .inport1_wr_i         (inport1_wr_i),
        .inport1_cacheable_i  (inport1_cacheable_i),
        .inport1_req_tag_i    (inport1_req_tag_i),
        .inport1_invalidate_i (inport1_invalidate_i),
        .inport1_flush_i      (inport1_flush_i),
        .inport1_accept_o     (inport1_accept_o),
        .inport1_ack_o        (inport1_ack_o),
        .inport1_error_o      (inport1_error_o),
        .inport1_data_rd_o    (inport1_data_rd_o),
        .inport1_resp_tag_o   (inport1_resp_tag_o),
        .outport_addr_o       (outport_addr_o),
        .outport_data_wr_o    (outport_data_wr_o),
        .outport_rd_o         (outport_rd_o),
        .outport_wr_o         (outport_wr_o),
        .outport_cacheable_o  (outport_cacheable_o),
        .outport_req_tag_o    (outport_req_tag_o),
        .outport_invalidate_o (outport_invalidate_o),
        .outport_flush_o      (outport_flush_o),
        .outport_accept_i     (outport_accept_i),
        .outport_ack_i        (outport_ack_i),
        .outport_error_i      (outport_error_i),
        .outport_data_rd_i    (outport_data_rd_i),
        .outport_resp_tag_i   (outport_resp_tag_i),
        .err_unexpected_o     (err_unexpected_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk_i);
    endtask

    task automatic clear_reqs();
        inport0_rd_i = 1'b0; inport0_wr_i = 4'h0; inport0_flush_i = 1'b0; inport0_invalidate_i = 1'b0;
        inport1_rd_i = 1'b0; inport1_wr_i = 4'h0; inport1_flush_i = 1'b0; inport1_invalidate_i = 1'b0;
    endtask

    task automatic idle_inputs();
        clear_reqs();
        inport0_addr_i = '0; inport0_data_wr_i = '0; inport0_cacheable_i = 1'b0; inport0_req_tag_i = '0;
        inport1_addr_i = '0; inport1_data_wr_i = '0; inport1_cacheable_i = 1'b0; inport1_req_tag_i = '0;
        outport_accept_i   = 1'b0;
        outport_ack_i      = 1'b0;
        outport_error_i    = 1'b0;
        outport_data_rd_i  = '0;
        outport_resp_tag_i = '0;
    endtask

    task automatic set_rd(input int p, input logic [31:0] addr);
        if (p == 0) begin
            inport0_rd_i = 1'b1; inport0_addr_i = addr; inport0_req_tag_i = addr[10:0];
        end else begin
            inport1_rd_i = 1'b1; inport1_addr_i = addr; inport1_req_tag_i = addr[10:0];
        end
    endtask

    task automatic set_wr(input int p, input logic [31:0] addr, input logic [3:0] strb);
        if (p == 0) begin
            inport0_wr_i = strb; inport0_addr_i = addr; inport0_data_wr_i = ~addr;
        end else begin
            inport1_wr_i = strb; inport1_addr_i = addr; inport1_data_wr_i = ~addr;
        end
    endtask

    // p = port expected to be accepted this cycle, -1 for none
    task automatic exp_acc(input string tag, input int p);
        check({tag, "_acc0"}, inport0_accept_o, p == 0);
        check({tag, "_acc1"}, inport1_accept_o, p == 1);
        if (p >= 0)
            sb.push_back(p);
    endtask

    // Drive a downstream ack and compare routing against the scoreboard
    task automatic do_ack(input string tag, input logic [31:0] data, input logic err);
        int owner;
        outport_ack_i      = 1'b1;
        outport_data_rd_i  = data;
        outport_error_i    = err;
        outport_resp_tag_i = data[10:0];
        #1;
        owner = (sb.size() > 0) ? sb.pop_front() : -1;
        check({tag, "_ack0"}, inport0_ack_o, owner == 0);
        check({tag, "_ack1"}, inport1_ack_o, owner == 1);
        if (owner >= 0) begin
            check({tag, "_data0"}, inport0_data_rd_o, data);
            check({tag, "_data1"}, inport1_data_rd_o, data);
            check({tag, "_tag"},   owner == 0 ? inport0_resp_tag_o : inport1_resp_tag_o, data[10:0]);
            check({tag, "_err"},   owner == 0 ? inport0_error_o    : inport1_error_o,    err);
        end
    endtask

    task automatic drain(input string tag, input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            cyc();
            do_ack(tag, base + i, 1'b0);
        end
        cyc();
        outport_ack_i   = 1'b0;
        outport_error_i = 1'b0;
    endtask

    task automatic do_reset();
        cyc();
        idle_inputs();
        rst_i = 1'b1;
        sb.delete();
        cyc();
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b0;
        idle_inputs();
        #2 rst_i = 1'b1;
        #1;
        // Reset state with idle inputs
        check("rst_acc0", inport0_accept_o, 1'b0);
        check("rst_acc1", inport1_accept_o, 1'b0);
        check("rst_ack0", inport0_ack_o, 1'b0);
        check("rst_ack1", inport1_ack_o, 1'b0);
        check("rst_err0", inport0_error_o, 1'b0);
        check("rst_err1", inport1_error_o, 1'b0);
        check("rst_rd",   outport_rd_o, 1'b0);
        check("rst_wr",   outport_wr_o, 4'h0);
        check("rst_unexp", err_unexpected_o, 1'b0);
        cyc(); cyc();
        rst_i = 1'b0;

        // Single read from port 0, ack two cycles later
        cyc();
        set_rd(0, 32'h0000_0100);
        outport_accept_i = 1'b1;
        #1;
        check("rd0_outrd", outport_rd_o, 1'b1);
        check("rd0_addr",  outport_addr_o, 32'h0000_0100);
        exp_acc("rd0", 0);
        cyc();
        clear_reqs();
        outport_accept_i = 1'b0;
        #1;
        exp_acc("rd0_idle", -1);
        cyc();
        do_ack("rd0", 32'hDEAD_BEEF, 1'b0);
        cyc();
        outport_ack_i = 1'b0;

        // Continuous contention after reset: strict alternation 0,1,0,1
        do_reset();
        cyc();
        set_wr(0, 32'h0000_00A0, 4'hF);
        set_wr(1, 32'h0000_00B0, 4'hF);
        outport_accept_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc();
            #1;
            exp_acc("rr", i % 2);
            check("rr_addr", outport_addr_o, (i % 2) ? 32'h0000_00B0 : 32'h0000_00A0);
            check("rr_wdata", outport_data_wr_o, (i % 2) ? ~32'h0000_00B0 : ~32'h0000_00A0);
        end
        cyc();
        clear_reqs();
        outport_accept_i = 1'b0;
        drain("rr", 4, 32'h0000_1000);

        // Stall with both requesting: grant locks on port 0 (last was 1)
        cyc();
        set_rd(0, 32'h0000_0200);
        set_rd(1, 32'h0000_0300);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc();
            #1;
            exp_acc("lock", -1);
            check("lock_addr", outport_addr_o, 32'h0000_0200);
            check("lock_rd",   outport_rd_o, 1'b1);
        end
        cyc();
        outport_accept_i = 1'b1;
        #1;
        exp_acc("lock_rel", 0);
        cyc();
        #1;
        exp_acc("lock_next", 1);
        cyc();
        clear_reqs();
        outport_accept_i = 1'b0;
        cyc();
        do_ack("lock_e", 32'h0000_2000, 1'b1);
        cyc();
        do_ack("lock_e", 32'h0000_2001, 1'b0);
        cyc();
        outport_ack_i = 1'b0;

        // Lock on port 1 survives a later port 0 request that would win RR
        cyc();
        set_rd(1, 32'h0000_0400);
        #1;
        exp_acc("lk1", -1);
        check("lk1_addr", outport_addr_o, 32'h0000_0400);
        cyc();
        set_rd(0, 32'h0000_0500);
        #1;
        exp_acc("lk1_hold", -1);
        check("lk1_hold_addr", outport_addr_o, 32'h0000_0400);
        cyc();
        outport_accept_i = 1'b1;
        #1;
        exp_acc("lk1_rel", 1);
        cyc();
        #1;
        exp_acc("lk1_next", 0);
        cyc();
        clear_reqs();
        outport_accept_i = 1'b0;
        drain("lk1", 2, 32'h0000_3000);

        // Full: four outstanding blocks the fifth; a pop unblocks next cycle
        cyc();
        set_rd(0, 32'h0000_0600);
        outport_accept_i = 1'b1;
        #1;
        exp_acc("fill", 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            exp_acc("fill", 0);
        end
        cyc();
        #1;
        check("full_rd",   outport_rd_o, 1'b0);
        check("full_addr", outport_addr_o, 32'h0000_0600);
        exp_acc("full", -1);
        cyc();
        do_ack("full_pop", 32'h0000_4000, 1'b0);
        exp_acc("full_pop", -1);
        cyc();
        outport_ack_i = 1'b0;
        #1;
        exp_acc("after_pop", 0);
        cyc();
        clear_reqs();
        outport_accept_i = 1'b0;
        drain("full", 4, 32'h0000_5000);

        // Reset with two requests outstanding; the later ack is stray
        cyc();
        set_rd(1, 32'h0000_0700);
        outport_accept_i = 1'b1;
        #1;
        exp_acc("pre_rst", 1);
        cyc();
        #1;
        exp_acc("pre_rst", 1);
        cyc();
        clear_reqs();
        outport_accept_i = 1'b0;
        rst_i = 1'b1;
        sb.delete();
        #1;
        check("mid_rst_rd",    outport_rd_o, 1'b0);
        check("mid_rst_ack0",  inport0_ack_o, 1'b0);
        check("mid_rst_ack1",  inport1_ack_o, 1'b0);
        check("mid_rst_unexp", err_unexpected_o, 1'b0);
        cyc();
        rst_i = 1'b0;
        cyc();
        do_ack("stray", 32'h0000_6000, 1'b0);
        check("stray_unexp_same", err_unexpected_o, 1'b0);
        cyc();
        outport_ack_i = 1'b0;
        #1;
        check("stray_unexp", err_unexpected_o, 1'b1);
        repeat (3) cyc();
        #1;
        check("stray_sticky", err_unexpected_o, 1'b1);
        cyc();
        rst_i = 1'b1;
        #1;
        check("unexp_clr", err_unexpected_o, 1'b0);
        cyc();
        rst_i = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
